// File: rtl/sipo_pkg.sv
// Shared constants for the 16-bit serial-in, parallel-out frame assembler.
package sipo_pkg;
   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int CNT_W = 3;

   localparam logic [WIDTH-1:0] RST_WORD = 16'h0000;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
endpackage : sipo_pkg

// File: rtl/sipo_16bit_if.sv
// Word-stream input and parallel frame output bundle of the frame assembler.
//
// Handshake: the stream has no back-pressure. A word is accepted on every
// rising clock edge where en=1; sof is sampled only on such an edge and tags
// din as word 0 of a new frame. valid is a one-cycle strobe (no ready) that
// marks y0..y7 as freshly updated; y0..y7 hold until the next completed frame.
interface sipo_16bit_if;
   import sipo_pkg::*;

   logic [WIDTH-1:0] din;
   logic             en;
   logic             sof;
   logic [WIDTH-1:0] y0;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] y2;
   logic [WIDTH-1:0] y3;
   logic [WIDTH-1:0] y4;
   logic [WIDTH-1:0] y5;
   logic [WIDTH-1:0] y6;
   logic [WIDTH-1:0] y7;
   logic             valid;
   logic             busy;
   logic [CNT_W-1:0] cnt;

   modport master (
      output din, en, sof,
      input  y0, y1, y2, y3, y4, y5, y6, y7, valid, busy, cnt
   );

   modport slave (
      input  din, en, sof,
      output y0, y1, y2, y3, y4, y5, y6, y7, valid, busy, cnt
   );
endinterface : sipo_16bit_if

// File: rtl/sipo_16bit_stage.sv
// One word-wide enable register with asynchronous active-low reset; used both
// for the shift chain and for the parallel output bank.
module sipo_stage
   import sipo_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] word_q;

   // Load d_i when enabled, otherwise hold.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         word_q <= W'(RST_WORD);
      end else if (en_i) begin
         word_q <= d_i;
      end
   end

   assign q_o = word_q;

endmodule : sipo_stage

// File: rtl/sipo_16bit.sv
// Serial-in, parallel-out frame assembler: collects eight accepted words into a
// frame and presents it on y0..y7 (y0 = first word) with a one-cycle valid.
module sipo_16bit
   import sipo_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   sipo_16bit_if.slave  bus
);

   logic [WIDTH-1:0] s_q [DEPTH];
   logic [WIDTH-1:0] s_d [DEPTH];
   logic [WIDTH-1:0] y_q [DEPTH];
   logic [WIDTH-1:0] y_d [DEPTH];

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             frame_done;

   // Eighth word of a frame: a plain accept while seven words are already held.
   // An sof on that edge restarts the frame instead of completing it.
   assign frame_done = bus.en && !bus.sof && (cnt_q == LAST_IDX);

   // The newest word enters at the top; y7 takes din directly because the
   // completing word never sits in the chain.
   assign s_d[DEPTH-1] = bus.din;
   assign y_d[DEPTH-1] = bus.din;

   genvar k;
   generate
      for (k = 0; k < DEPTH - 1; k++) begin : g_link
         assign s_d[k] = s_q[k+1];
         assign y_d[k] = s_q[k+1];
      end

      for (k = 0; k < DEPTH; k++) begin : g_bank
         sipo_stage #(.W(WIDTH)) u_shift (
            .clk_i  (clk),
            .rst_ni (rst),
            .en_i   (bus.en),
            .d_i    (s_d[k]),
            .q_o    (s_q[k])
         );

         sipo_stage #(.W(WIDTH)) u_out (
            .clk_i  (clk),
            .rst_ni (rst),
            .en_i   (frame_done),
            .d_i    (y_d[k]),
            .q_o    (y_q[k])
         );
      end
   endgenerate

   // Word counter: sof restarts at one, otherwise count up and wrap 7 -> 0.
   always_comb begin
      cnt_d   = cnt_q;
      valid_d = frame_done;
      if (bus.en) begin
         if (bus.sof) begin
            cnt_d = CNT_W'(1);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Counter and valid strobe registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign bus.cnt   = cnt_q;
   assign bus.busy  = (cnt_q != '0);
   assign bus.valid = valid_q;
   assign bus.y0    = y_q[0];
   assign bus.y1    = y_q[1];
   assign bus.y2    = y_q[2];
   assign bus.y3    = y_q[3];
   assign bus.y4    = y_q[4];
   assign bus.y5    = y_q[5];
   assign bus.y6    = y_q[6];
   assign bus.y7    = y_q[7];

endmodule : sipo_16bit

// File: doc/sipo_16bit.md
# sipo_16bit

Serial-in, parallel-out frame assembler for 16-bit words. It accepts one word per clock from a word-serial stream, collects eight consecutive words into a frame, and presents the whole frame on eight parallel 16-bit outputs with a one-cycle valid strobe. It is the receive end of the 8-word parallel-to-serial shifter: word 0 of a frame (the first word on the line) lands on `y0`, and word 7 lands on `y7`.

## Interface
- `WIDTH`, 16, word width; all data ports use this width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  serial word input.
- `en`  in  1  word-accept qualifier; `din` is captured on a rising edge where `en`=1.
- `sof`  in  1  start of frame; meaningful only when `en`=1; marks `din` as word 0.
- `y7`..`y0`  out  WIDTH each  last completed frame; `y0` holds the first word, `y7` the last.
- `valid`  out  1  one-cycle pulse when `y7`..`y0` have just been updated.
- `busy`  out  1  a partial frame is in progress (`cnt`≠0).
- `cnt`  out  3  number of words of the current partial frame already accepted (0–7).

## Operation
- Reset (`rst`=0, asynchronous): shift stages, `y7`..`y0` = 16'h0000; `cnt`=0; `valid`=0; `busy`=0.
- Internal shift chain s7..s0. On each accepted word: s7←`din`, s(k)←s(k+1) for k=6..0. After eight accepts, s0 holds word 0.
- Counter: on accept with `sof`=0, `cnt`←`cnt`+1, wrapping from 7 to 0. On accept with `sof`=1, `cnt`←1 and the partial frame is discarded; `din` becomes word 0.
- Frame completion: an accept in which `cnt`=7 and `sof`=0 is the 8th word. On that edge: `y0`..`y6`←s1..s7, `y7`←`din`, `valid`←1, `cnt`←0.
- `valid` is 1 for exactly one cycle after the completing edge, and 0 otherwise. `y` outputs hold their value until the next completion.
- `en`=0 pauses the frame: there is no shift and no count change. Gaps between words are allowed and unbounded.
- `sof`=1 with `en`=0 is ignored.
- Stream without `sof`: every 8 consecutive accepts form a frame. Alignment is by count only.

## Timing
- Latency: `y`/`valid` are registered and update on the same edge that accepts word 7, so they are visible in the following cycle.
- Throughput: one word per clock. Back-to-back frames give `valid` every 8th cycle, with no dead cycle.
- `sof` on the cycle right after completion starts the new frame normally (`cnt` 0→1).
- `sof` while `cnt`=7: the frame restarts and no `valid` is produced. `y` keeps the previous frame.
- Reset asserted mid-frame clears everything immediately. The first accept after release is word 0, whether or not `sof` is set.
- `busy` is combinational from `cnt` (`cnt`≠0).

## Structure
- Shared package/header `sipo_pkg`: `WIDTH`=16, `DEPTH`=8, `CNT_W`=3, reset word value 16'h0000.
- One natural sub-module: `sipo_stage`, a WIDTH-bit enable register with active-low asynchronous reset. It is instantiated 8× for the shift chain and 8× for the output bank.
- Counter, `sof` handling and `valid` logic stay in the top level.

## Test plan
- Reset: hold `rst`=0 with `en`=1 and `din` toggling → all `y`=0000, `valid`=0, `cnt`=0; release → first accepted word counts as word 0.
- Single frame: `sof`=1 with 0x1000, then 0x1001..0x1007 on consecutive cycles → one `valid` pulse; `y0`=1000 … `y7`=1007; `cnt` back to 0.
- Gapped frame: same eight words with `en`=0 for 3 cycles between words 2 and 3 → identical `y` values; `valid` only after word 7; `cnt` holds at 3 during the gap.
- Resync: five words 0xAAA0..0xAAA4, then `sof` with 0xB000..0xB007 → no `valid` for the A words; `y0`=B000 … `y7`=B007.
- Back-to-back: frames 0xC000..C007 and 0xD000..D007 with no gap → `valid` exactly 8 cycles apart; second frame holds `y7`=D007.
- Mid-frame reset: pulse `rst`=0 after 4 words → `cnt`=0 and `y` cleared at once; the next 8 words form a complete frame.
